// File: rtl/bsg_link_pearl_reset_seq_pkg.sv
// Shared types for the bsg_link pearl hardware reset sequencer.
// Defines the FSM states, the per-channel reset bundle and small helper functions.
package bsg_link_pearl_reset_seq_pkg;

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    CLKGEN   = 4'd1,
    ASSERT   = 4'd2,
    TOKEN_HI = 4'd3,
    TOKEN_LO = 4'd4,
    UP_REL   = 4'd5,
    DOWN_REL = 4'd6,
    CORE_REL = 4'd7,
    DONE     = 4'd8
  } bsg_link_pearl_reset_seq_state_e;

  typedef struct packed {
    logic clk_gen;
    logic token;
    logic up_io;
    logic down_io;
    logic core;
  } bsg_link_pearl_chan_reset_s;

  // Number of timed steps in one bring-up sequence.
  function automatic int unsigned bsg_link_pearl_reset_seq_steps_gp(input bit ddr);
    return ddr ? 32'd7 : 32'd6;
  endfunction

  // Fully-held reset bundle; the io clk-gen reset only exists on DDR links.
  function automatic bsg_link_pearl_chan_reset_s bsg_link_pearl_chan_reset_value(input bit ddr);
    bsg_link_pearl_chan_reset_s v;
    v.clk_gen = ddr;
    v.token   = 1'b0;
    v.up_io   = 1'b1;
    v.down_io = 1'b1;
    v.core    = 1'b1;
    return v;
  endfunction

  function automatic bsg_link_pearl_reset_seq_state_e bsg_link_pearl_reset_seq_next_step
    (input bsg_link_pearl_reset_seq_state_e s);
    bsg_link_pearl_reset_seq_state_e n;
    case (s)
      CLKGEN:   n = ASSERT;
      ASSERT:   n = TOKEN_HI;
      TOKEN_HI: n = TOKEN_LO;
      TOKEN_LO: n = UP_REL;
      UP_REL:   n = DOWN_REL;
      DOWN_REL: n = CORE_REL;
      CORE_REL: n = DONE;
      default:  n = s;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/bsg_link_pearl_reset_seq_if.sv
// Control/status bundle between a bring-up host and the pearl reset sequencer.
// The slave side is the sequencer; the master side requests and observes the sequence.
interface bsg_link_pearl_reset_seq_if #(
  parameter int unsigned num_channels_p = 2
);

  logic                      start_i;
  logic [num_channels_p-1:0] channel_en_i;
  logic [num_channels_p-1:0] clk_gen_reset_o;
  logic [num_channels_p-1:0] token_reset_o;
  logic [num_channels_p-1:0] up_io_reset_o;
  logic [num_channels_p-1:0] down_io_reset_o;
  logic [num_channels_p-1:0] core_reset_o;
  logic                      busy_o;
  logic                      done_o;

  modport master (
    output start_i,
    output channel_en_i,
    input  clk_gen_reset_o,
    input  token_reset_o,
    input  up_io_reset_o,
    input  down_io_reset_o,
    input  core_reset_o,
    input  busy_o,
    input  done_o
  );

  modport slave (
    input  start_i,
    input  channel_en_i,
    output clk_gen_reset_o,
    output token_reset_o,
    output up_io_reset_o,
    output down_io_reset_o,
    output core_reset_o,
    output busy_o,
    output done_o
  );

endinterface

// File: rtl/bsg_link_pearl_reset_seq_timer.sv
// Step hold timer: clear-and-count-up counter, cleared on every sequencer state change.
module bsg_link_pearl_reset_seq_timer #(
  parameter int unsigned width_p = 5
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               clear_i,
  input  logic               up_i,
  output logic [width_p-1:0] count_o
);

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      count_o <= '0;
    end else if (clear_i) begin
      count_o <= '0;
    end else if (up_i) begin
      count_o <= count_o + width_p'(1);
    end
  end

endmodule

// File: rtl/bsg_link_pearl_reset_seq.sv
// Fixed, timed bring-up sequencer for N bsg_link pearl channels.
// Enabled channels step through clk-gen/io/token/core resets in lockstep; disabled channels stay in reset.
module bsg_link_pearl_reset_seq
  import bsg_link_pearl_reset_seq_pkg::*;
#(
  parameter int unsigned num_channels_p = 2,
  parameter bit          ddr_p          = 1'b1,
  parameter int unsigned hold_cycles_p  = 16
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  bsg_link_pearl_reset_seq_if.slave link
);

  localparam int unsigned cnt_width_lp = $clog2(hold_cycles_p + 1);
  localparam logic [cnt_width_lp-1:0] last_cnt_lp = cnt_width_lp'(hold_cycles_p - 1);
  localparam bsg_link_pearl_chan_reset_s chan_reset_lp = bsg_link_pearl_chan_reset_value(ddr_p);

  if (hold_cycles_p < 1) begin : g_hold_chk
    $error("bsg_link_pearl_reset_seq: hold_cycles_p must be >= 1");
  end
  if (num_channels_p < 1) begin : g_chan_chk
    $error("bsg_link_pearl_reset_seq: num_channels_p must be >= 1");
  end

  bsg_link_pearl_reset_seq_state_e state_r, state_n;
  logic [cnt_width_lp-1:0]         count;
  logic [num_channels_p-1:0]       en_r;
  bsg_link_pearl_chan_reset_s [num_channels_p-1:0] chan_r, chan_n;
  logic                            busy_r, done_r;
  logic                            in_step, hold_done, start_ok;

  assign in_step   = (state_r != IDLE) && (state_r != DONE);
  assign hold_done = in_step && (count == last_cnt_lp);
  assign start_ok  = !in_step && link.start_i;

  bsg_link_pearl_reset_seq_timer #(
    .width_p (cnt_width_lp)
  ) timer (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .clear_i (state_n != state_r),
    .up_i    (in_step),
    .count_o (count)
  );

  always_comb begin
    state_n = state_r;
    unique case (state_r)
      IDLE, DONE: if (link.start_i) state_n = ddr_p ? CLKGEN : ASSERT;
      default:    if (hold_done) state_n = bsg_link_pearl_reset_seq_next_step(state_r);
    endcase
  end

  // ASSERT re-arms every reset as well, so an SDR restart from DONE starts from a clean state.
  always_comb begin
    chan_n = chan_r;
    for (int unsigned i = 0; i < num_channels_p; i++) begin
      if (!en_r[i]) begin
        chan_n[i] = chan_reset_lp;
      end else begin
        unique case (state_r)
          CLKGEN:   chan_n[i] = chan_reset_lp;
          ASSERT: begin
            chan_n[i]         = chan_reset_lp;
            chan_n[i].clk_gen = 1'b0;
          end
          TOKEN_HI: chan_n[i].token   = 1'b1;
          TOKEN_LO: chan_n[i].token   = 1'b0;
          UP_REL:   chan_n[i].up_io   = 1'b0;
          DOWN_REL: chan_n[i].down_io = 1'b0;
          CORE_REL: chan_n[i].core    = 1'b0;
          default:  ;
        endcase
      end
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_r <= IDLE;
      en_r    <= '0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      chan_r  <= {num_channels_p{chan_reset_lp}};
    end else begin
      state_r <= state_n;
      if (start_ok) en_r <= link.channel_en_i;
      busy_r  <= in_step;
      done_r  <= (state_r == DONE);
      chan_r  <= chan_n;
    end
  end

  for (genvar i = 0; i < num_channels_p; i++) begin : g_out
    assign link.clk_gen_reset_o[i] = chan_r[i].clk_gen;
    assign link.token_reset_o[i]   = chan_r[i].token;
    assign link.up_io_reset_o[i]   = chan_r[i].up_io;
    assign link.down_io_reset_o[i] = chan_r[i].down_io;
    assign link.core_reset_o[i]    = chan_r[i].core;
  end

  assign link.busy_o = busy_r;
  assign link.done_o = done_r;

endmodule

// File: tb/tb_bsg_link_pearl_reset_seq.sv
// Scoreboard bench for the pearl reset sequencer: three configurations run side by side,
// a timeline model pushes the expected outputs each cycle and the monitor pops and compares them.
module tb_bsg_link_pearl_reset_seq;

  typedef struct packed {
    logic       busy;
    logic       done;
    logic [3:0] cg;
    logic [3:0] tk;
    logic [3:0] up;
    logic [3:0] dn;
    logic [3:0] co;
  } obs_t;

  typedef struct {
    int unsigned inst;
    int unsigned cyc;
    obs_t        val;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bsg_link_pearl_reset_seq_if #(.num_channels_p(2)) a_if ();
  bsg_link_pearl_reset_seq_if #(.num_channels_p(2)) b_if ();
  bsg_link_pearl_reset_seq_if #(.num_channels_p(4)) c_if ();

  bsg_link_pearl_reset_seq #(.num_channels_p(2), .ddr_p(1'b1), .hold_cycles_p(16)) dut_a (
    .clk_i(clk), .reset_i(rst), .link(a_if.slave));
  bsg_link_pearl_reset_seq #(.num_channels_p(2), .ddr_p(1'b0), .hold_cycles_p(4)) dut_b (
    .clk_i(clk), .reset_i(rst), .link(b_if.slave));
  bsg_link_pearl_reset_seq #(.num_channels_p(4), .ddr_p(1'b1), .hold_cycles_p(1)) dut_c (
    .clk_i(clk), .reset_i(rst), .link(c_if.slave));

  int unsigned hold_m [3] = '{16, 4, 1};
  bit          ddr_m  [3] = '{1'b1, 1'b0, 1'b1};
  int unsigned n_m    [3] = '{2, 2, 4};

  bit          act [3];
  bit          pact [3];
  int unsigned s [3];
  int unsigned ps [3];
  logic [3:0]  en_m [3];
  logic [3:0]  pen [3];
  int unsigned cyc = 0;
  exp_t        sb [$];

  int total = 0;
  int bad   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Timeline model: t counts edges since the accepted start edge (t >= 1).
  function automatic obs_t model(input bit active, input int unsigned t, input bit ddr,
                                 input int unsigned hold, input logic [3:0] en, input int unsigned n);
    obs_t o;
    int unsigned steps;
    int j;
    o = '0;
    j = 7;
    steps = ddr ? 7 : 6;
    if (active) begin
      if (t <= steps * hold) begin
        o.busy = 1'b1;
        j = int'((t - 1) / hold) + (ddr ? 0 : 1);
      end else begin
        o.done = 1'b1;
      end
    end
    for (int i = 0; i < int'(n); i++) begin
      if (active && en[i]) begin
        o.cg[i] = ddr && (j == 0);
        o.tk[i] = (j == 2);
        o.up[i] = (j < 4);
        o.dn[i] = (j < 5);
        o.co[i] = (j < 6);
      end else begin
        o.cg[i] = ddr;
        o.tk[i] = 1'b0;
        o.up[i] = 1'b1;
        o.dn[i] = 1'b1;
        o.co[i] = 1'b1;
      end
    end
    return o;
  endfunction

  function automatic obs_t expect_of(input int unsigned x);
    if (act[x] && cyc > s[x])
      return model(1'b1, cyc - s[x], ddr_m[x], hold_m[x], en_m[x], n_m[x]);
    else if (act[x] && pact[x])
      return model(1'b1, cyc - ps[x], ddr_m[x], hold_m[x], pen[x], n_m[x]);
    else
      return model(1'b0, 0, ddr_m[x], hold_m[x], 4'b0, n_m[x]);
  endfunction

  function automatic obs_t observe(input int unsigned x);
    obs_t o;
    case (x)
      0: o = {a_if.busy_o, a_if.done_o, 4'(a_if.clk_gen_reset_o), 4'(a_if.token_reset_o),
              4'(a_if.up_io_reset_o), 4'(a_if.down_io_reset_o), 4'(a_if.core_reset_o)};
      1: o = {b_if.busy_o, b_if.done_o, 4'(b_if.clk_gen_reset_o), 4'(b_if.token_reset_o),
              4'(b_if.up_io_reset_o), 4'(b_if.down_io_reset_o), 4'(b_if.core_reset_o)};
      default: o = {c_if.busy_o, c_if.done_o, c_if.clk_gen_reset_o, c_if.token_reset_o,
                    c_if.up_io_reset_o, c_if.down_io_reset_o, c_if.core_reset_o};
    endcase
    return o;
  endfunction

  function automatic logic start_of(input int unsigned x);
    case (x)
      0:       return a_if.start_i;
      1:       return b_if.start_i;
      default: return c_if.start_i;
    endcase
  endfunction

  function automatic logic [3:0] en_of(input int unsigned x);
    case (x)
      0:       return 4'(a_if.channel_en_i);
      1:       return 4'(b_if.channel_en_i);
      default: return c_if.channel_en_i;
    endcase
  endfunction

  // Model + monitor: push expectations at the active edge, compare on the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      cyc++;
      for (int unsigned x = 0; x < 3; x++) begin
        if (rst) begin
          act[x]  = 1'b0;
          pact[x] = 1'b0;
        end else if (start_of(x) &&
                     (!act[x] || cyc > s[x] + (ddr_m[x] ? 7 : 6) * hold_m[x])) begin
          pact[x] = act[x];
          ps[x]   = s[x];
          pen[x]  = en_m[x];
          act[x]  = 1'b1;
          s[x]    = cyc;
          en_m[x] = en_of(x);
        end
        sb.push_back('{inst: x, cyc: cyc, val: expect_of(x)});
      end
      @(negedge clk);
      while (sb.size() > 0) begin
        e = sb.pop_front();
        check_eq($sformatf("inst%0d@%0d", e.inst, e.cyc), 32'(observe(e.inst)), 32'(e.val));
      end
    end
  end

  task automatic reset_check(input string tag);
    for (int unsigned x = 0; x < 3; x++)
      check_eq($sformatf("%s_inst%0d", tag, x), 32'(observe(x)),
               32'(model(1'b0, 0, ddr_m[x], hold_m[x], 4'b0, n_m[x])));
  endtask

  task automatic pulse_a(input logic [1:0] en);
    a_if.start_i = 1'b1;
    a_if.channel_en_i = en;
    @(negedge clk);
    a_if.start_i = 1'b0;
    a_if.channel_en_i = ~en;
  endtask

  initial begin
    a_if.start_i = 1'b0; a_if.channel_en_i = '0;
    b_if.start_i = 1'b0; b_if.channel_en_i = '0;
    c_if.start_i = 1'b0; c_if.channel_en_i = '0;
    repeat (3) @(negedge clk);
    reset_check("rst_init");
    rst = 1'b0;
    @(negedge clk);

    // All three configurations start together; enables then wander with no effect.
    a_if.start_i = 1'b1; a_if.channel_en_i = 2'b11;
    b_if.start_i = 1'b1; b_if.channel_en_i = 2'b01;
    c_if.start_i = 1'b1; c_if.channel_en_i = 4'b1011;
    @(negedge clk);
    a_if.start_i = 1'b0; a_if.channel_en_i = 2'b00;
    b_if.start_i = 1'b0; b_if.channel_en_i = 2'b10;
    c_if.start_i = 1'b0; c_if.channel_en_i = 4'b0100;
    @(negedge clk);
    c_if.start_i = 1'b1;
    @(negedge clk);
    c_if.start_i = 1'b0;
    repeat (26) @(negedge clk);
    pulse_a(2'b01);
    repeat (100) @(negedge clk);

    // Restart from DONE with only channel 1 enabled.
    pulse_a(2'b10);
    repeat (125) @(negedge clk);

    // Abort mid token pulse, then run a full sequence again.
    pulse_a(2'b11);
    repeat (40) @(negedge clk);
    #2 rst = 1'b1;
    #1 reset_check("rst_mid");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    pulse_a(2'b11);
    repeat (125) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
